// File: rtl/pipe_stage_skid_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_pkg
// Shared pipeline definitions for the inter-stage skid register.
//   occ_e          : occupancy encodings of a 2-entry stage (0, 1 or 2 beats)
//   FLD_*          : bit offsets/widths of the fields packed into the 64-bit
//                    stage payload (control, operand tags, PC, immediate,
//                    instruction)
//   pack_payload() : assembles the fields into one payload word
// ---------------------------------------------------------------------------
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam int PAYLOAD_W    = 64;

    localparam int FLD_INSN_LSB = 0;
    localparam int FLD_INSN_W   = 16;
    localparam int FLD_IMM_LSB  = 16;
    localparam int FLD_IMM_W    = 12;
    localparam int FLD_PC_LSB   = 28;
    localparam int FLD_PC_W     = 16;
    localparam int FLD_OPS_LSB  = 44;
    localparam int FLD_OPS_W    = 16;
    localparam int FLD_CTRL_LSB = 60;
    localparam int FLD_CTRL_W   = 4;

    function automatic logic [PAYLOAD_W-1:0] pack_payload(
        input logic [FLD_CTRL_W-1:0] ctrl,
        input logic [FLD_OPS_W-1:0]  ops,
        input logic [FLD_PC_W-1:0]   pc,
        input logic [FLD_IMM_W-1:0]  imm,
        input logic [FLD_INSN_W-1:0] insn
    );
        logic [PAYLOAD_W-1:0] w;
        w = '0;
        w[FLD_CTRL_LSB +: FLD_CTRL_W] = ctrl;
        w[FLD_OPS_LSB  +: FLD_OPS_W]  = ops;
        w[FLD_PC_LSB   +: FLD_PC_W]   = pc;
        w[FLD_IMM_LSB  +: FLD_IMM_W]  = imm;
        w[FLD_INSN_LSB +: FLD_INSN_W] = insn;
        return w;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at all-ones instead of wrapping.
//   clk    : clock, rising edge
//   rst    : asynchronous, active-low reset (count -> 0)
//   i_clr  : synchronous clear, wins over i_inc
//   i_inc  : add one this cycle unless already saturated
//   o_cnt  : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state is written with <= only, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Inter-stage pipeline register with valid/ready handshake and a 2-entry
// skid buffer (main + skid register). o_in_ready comes from a flop, so the
// downstream ready never ripples combinationally into the upstream stage.
//   clk, rst      : clock (rising) / async active-low reset
//   i_flush       : synchronous flush, drops every held beat and the beat
//                   presented in the same cycle; captures i_in_keep
//   i_in_valid / o_in_ready / i_in_data / i_in_keep   : upstream side
//   o_out_valid / i_out_ready / o_out_data / o_out_keep : downstream side
//   o_occupancy   : beats held (0, 1, 2)
//   o_stall_cnt   : saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int DATA_W        = 64,
    parameter int KEEP_W        = 1,
    parameter int CNT_W         = 16,
    parameter bit ZERO_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic [KEEP_W-1:0] i_in_keep,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [KEEP_W-1:0] o_out_keep,
    output logic [1:0]        o_occupancy,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    import pipe_stage_skid_pkg::*;

    occ_e              r_occ;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [KEEP_W-1:0] r_main_keep;
    logic [DATA_W-1:0] r_skid_data;
    logic [KEEP_W-1:0] r_skid_keep;

    logic w_accept;
    logic w_retire;
    logic w_stall;

    assign w_accept = i_in_valid  & r_in_ready;
    assign w_retire = r_out_valid & i_out_ready;
    assign w_stall  = r_out_valid & ~i_out_ready;

    // in_ready and out_valid are registered alongside the occupancy so each
    // branch sets them from the occupancy it moves to.
    // NOTE: both payload registers are plain flops with async reset; nothing
    // here maps to a RAM, so clearing them on reset costs nothing special.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ       <= OCC_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_data <= '0;
            r_main_keep <= '0;
            r_skid_data <= '0;
            r_skid_keep <= '0;
        end else if (i_flush) begin
            // A retire in this cycle has already been taken downstream; the
            // incoming beat is dropped even though in_ready may be high.
            r_occ       <= OCC_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            if (ZERO_ON_FLUSH) begin
                r_main_data <= '0;
            end
            r_main_keep <= i_in_keep;
            r_skid_data <= '0;
            r_skid_keep <= '0;
        end else begin
            unique case (r_occ)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        r_main_data <= i_in_data;
                        r_main_keep <= i_in_keep;
                        r_occ       <= OCC_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && w_retire) begin
                        r_main_data <= i_in_data;
                        r_main_keep <= i_in_keep;
                    end else if (w_accept) begin
                        // Head is stalled: park the new beat behind it.
                        r_skid_data <= i_in_data;
                        r_skid_keep <= i_in_keep;
                        r_occ       <= OCC_FULL;
                        r_in_ready  <= 1'b0;
                    end else if (w_retire) begin
                        r_occ       <= OCC_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                OCC_FULL: begin
                    if (w_retire) begin
                        r_main_data <= r_skid_data;
                        r_main_keep <= r_skid_keep;
                        r_occ       <= OCC_ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_occ       <= OCC_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_inc (w_stall),
        .o_cnt (o_stall_cnt)
    );

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_main_data;
    assign o_out_keep  = r_main_keep;
    assign o_occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
// Directed bench for pipe_stage_skid. Instance "a" uses the default build;
// instance "b" is built with ZERO_ON_FLUSH=0 and CNT_W=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

    import pipe_stage_skid_pkg::*;

    logic clk;
    logic rst;

    // instance a (defaults)
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [0:0]  a_in_keep, a_out_keep;
    logic [1:0]  a_occ;
    logic [15:0] a_stall;

    // instance b (ZERO_ON_FLUSH=0, CNT_W=4)
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_data, b_out_data;
    logic [0:0]  b_in_keep, b_out_keep;
    logic [1:0]  b_occ;
    logic [3:0]  b_stall;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_stage_skid u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (a_flush),
        .i_in_valid  (a_in_valid),
        .o_in_ready  (a_in_ready),
        .i_in_data   (a_in_data),
        .i_in_keep   (a_in_keep),
        .o_out_valid (a_out_valid),
        .i_out_ready (a_out_ready),
        .o_out_data  (a_out_data),
        .o_out_keep  (a_out_keep),
        .o_occupancy (a_occ),
        .o_stall_cnt (a_stall)
    );

    pipe_stage_skid #(
        .DATA_W        (64),
        .KEEP_W        (1),
        .CNT_W         (4),
        .ZERO_ON_FLUSH (1'b0)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (b_flush),
        .i_in_valid  (b_in_valid),
        .o_in_ready  (b_in_ready),
        .i_in_data   (b_in_data),
        .i_in_keep   (b_in_keep),
        .o_out_valid (b_out_valid),
        .i_out_ready (b_out_ready),
        .o_out_data  (b_out_data),
        .o_out_keep  (b_out_keep),
        .o_occupancy (b_occ),
        .o_stall_cnt (b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // status words are {out_valid, in_ready, occupancy}
    task automatic test_reset();
        rst        = 1'b0;
        a_flush    = 1'b0; a_in_valid = 1'b1; a_in_data = 64'hDEAD; a_in_keep = 1'b1; a_out_ready = 1'b0;
        b_flush    = 1'b0; b_in_valid = 1'b1; b_in_data = 64'hBEEF; b_in_keep = 1'b1; b_out_ready = 1'b0;
        #2;
        repeat (3) tick();
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_occ} !== 4'b0100) begin
            $display("FAIL reset_status_during: got %b want 0100", {a_out_valid, a_in_ready, a_occ});
            n_fail++;
        end
        n_cmp++;
        if ({a_out_data, a_out_keep, a_stall} !== 81'd0) begin
            $display("FAIL reset_data_during: got data=%h keep=%b stall=%0d want 0", a_out_data, a_out_keep, a_stall);
            n_fail++;
        end
        n_cmp++;
        if ({b_out_valid, b_in_ready, b_occ, b_stall} !== 8'b0100_0000) begin
            $display("FAIL reset_b_during: got %b want 01000000", {b_out_valid, b_in_ready, b_occ, b_stall});
            n_fail++;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_occ, a_stall} !== {4'b0100, 16'd0}) begin
            $display("FAIL reset_after_release: got valid=%b ready=%b occ=%0d stall=%0d want 0 1 0 0",
                     a_out_valid, a_in_ready, a_occ, a_stall);
            n_fail++;
        end
        a_in_valid = 1'b0; a_in_keep = 1'b0;
        b_in_valid = 1'b0; b_in_keep = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        logic [63:0] beats [4];
        beats[0] = 64'h11;
        beats[1] = 64'h22;
        beats[2] = 64'h33;
        beats[3] = pack_payload(4'hA, 16'h1234, 16'hBEEF, 12'h567, 16'h89AB);
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = beats[i];
            tick();
            n_cmp++;
            if ({a_out_valid, a_in_ready, a_occ} !== 4'b1101) begin
                $display("FAIL stream_status[%0d]: got %b want 1101", i, {a_out_valid, a_in_ready, a_occ});
                n_fail++;
            end
        end
        // last beat exercises the packed field layout
        n_cmp++;
        if (a_out_data !== 64'hA123_4BEE_F567_89AB) begin
            $display("FAIL stream_packed: got %h want a1234beef56789ab", a_out_data);
            n_fail++;
        end
        a_in_valid = 1'b0;
        tick();
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_occ, a_stall} !== {4'b0100, 16'd0}) begin
            $display("FAIL stream_drain: got valid=%b ready=%b occ=%0d stall=%0d want 0 1 0 0",
                     a_out_valid, a_in_ready, a_occ, a_stall);
            n_fail++;
        end
    endtask

    task automatic test_stream_data();
        // each beat shows up on out_data the cycle after it is presented
        logic [63:0] beats [3];
        beats[0] = 64'h11;
        beats[1] = 64'h22;
        beats[2] = 64'h33;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = beats[i];
            tick();
            n_cmp++;
            if (a_out_data !== beats[i]) begin
                $display("FAIL stream_data[%0d]: got %h want %h", i, a_out_data, beats[i]);
                n_fail++;
            end
        end
        a_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 64'hA;
        tick();
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_occ, a_out_data} !== {4'b1101, 64'hA}) begin
            $display("FAIL bp_one: got status=%b data=%h want 1101 a", {a_out_valid, a_in_ready, a_occ}, a_out_data);
            n_fail++;
        end
        a_in_data = 64'hB;
        tick();
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_occ, a_out_data} !== {4'b1010, 64'hA}) begin
            $display("FAIL bp_full: got status=%b data=%h want 1010 a", {a_out_valid, a_in_ready, a_occ}, a_out_data);
            n_fail++;
        end
        // presented while full: must not be taken
        a_in_data = 64'hEE;
        tick();
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_occ, a_out_data, a_stall} !== {4'b1010, 64'hA, 16'd2}) begin
            $display("FAIL bp_hold: got status=%b data=%h stall=%0d want 1010 a 2",
                     {a_out_valid, a_in_ready, a_occ}, a_out_data, a_stall);
            n_fail++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick();
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_occ, a_out_data} !== {4'b1101, 64'hB}) begin
            $display("FAIL bp_skid_move: got status=%b data=%h want 1101 b", {a_out_valid, a_in_ready, a_occ}, a_out_data);
            n_fail++;
        end
        tick();
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_occ, a_stall} !== {4'b0100, 16'd2}) begin
            $display("FAIL bp_drain: got status=%b stall=%0d want 0100 2", {a_out_valid, a_in_ready, a_occ}, a_stall);
            n_fail++;
        end
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_keep   = 1'b0;
        a_in_data   = 64'h01;
        tick();
        a_in_data   = 64'h02;
        tick();
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_occ, a_stall} !== {4'b1010, 16'd3}) begin
            $display("FAIL flush_prefill: got status=%b stall=%0d want 1010 3", {a_out_valid, a_in_ready, a_occ}, a_stall);
            n_fail++;
        end
        a_flush   = 1'b1;
        a_in_data = 64'hC;
        a_in_keep = 1'b1;
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        a_in_keep  = 1'b0;
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_occ} !== 4'b0100) begin
            $display("FAIL flush_status: got %b want 0100", {a_out_valid, a_in_ready, a_occ});
            n_fail++;
        end
        n_cmp++;
        if ({a_out_data, a_out_keep, a_stall} !== {64'd0, 1'b1, 16'd4}) begin
            $display("FAIL flush_data: got data=%h keep=%b stall=%0d want 0 1 4", a_out_data, a_out_keep, a_stall);
            n_fail++;
        end
        a_out_ready = 1'b1;
        tick();
        n_cmp++;
        if ({a_out_valid, a_occ, a_out_data} !== {3'b000, 64'd0}) begin
            $display("FAIL flush_dropped: got valid=%b occ=%0d data=%h want 0 0 0", a_out_valid, a_occ, a_out_data);
            n_fail++;
        end
    endtask

    task automatic test_flush_hold();
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 64'h55;
        tick();
        b_in_valid = 1'b0;
        b_flush    = 1'b1;
        tick();
        b_flush = 1'b0;
        n_cmp++;
        if ({b_out_valid, b_in_ready, b_occ, b_out_data, b_out_keep} !== {4'b0100, 64'h55, 1'b0}) begin
            $display("FAIL flush_hold: got status=%b data=%h keep=%b want 0100 55 0",
                     {b_out_valid, b_in_ready, b_occ}, b_out_data, b_out_keep);
            n_fail++;
        end
    endtask

    task automatic test_stall_saturate();
        // b_stall is 1 from the cycle before the flush in test_flush_hold
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 64'h66;
        tick();
        b_in_valid = 1'b0;
        repeat (13) tick();
        n_cmp++;
        if (b_stall !== 4'd14) begin
            $display("FAIL stall_pre_sat: got %0d want 14", b_stall);
            n_fail++;
        end
        tick();
        n_cmp++;
        if (b_stall !== 4'd15) begin
            $display("FAIL stall_at_sat: got %0d want 15", b_stall);
            n_fail++;
        end
        repeat (6) tick();
        n_cmp++;
        if ({b_stall, b_out_valid, b_out_data} !== {4'd15, 1'b1, 64'h66}) begin
            $display("FAIL stall_no_wrap: got stall=%0d valid=%b data=%h want 15 1 66", b_stall, b_out_valid, b_out_data);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 64'h77;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_occ, a_out_data, a_stall} !== {4'b0100, 64'd0, 16'd0}) begin
            $display("FAIL reset_mid: got status=%b data=%h stall=%0d want 0100 0 0",
                     {a_out_valid, a_in_ready, a_occ}, a_out_data, a_stall);
            n_fail++;
        end
        a_in_valid = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stream_data();
        test_backpressure();
        test_flush();
        test_flush_hold();
        test_stall_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
